// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Launch, mthi/mtlo and result bundle of the iterative
//               multiply/divide unit. Signal directions are named from the
//               unit's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_whi;
   logic             i_wlo;
   logic [WIDTH-1:0] i_wdata;
   logic             o_busy;
   logic             o_done;
   logic             o_div0;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;

   // The unit itself
   modport slave (
      input  i_start, i_op, i_a, i_b, i_whi, i_wlo, i_wdata,
      output o_busy, o_done, o_div0, o_hi, o_lo
   );

   // Pipeline control / datapath driving the unit
   modport master (
      output i_start, i_op, i_a, i_b, i_whi, i_wlo, i_wdata,
      input  o_busy, o_done, o_div0, o_hi, o_lo
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               Shift-add multiply and restoring divide on operand
//               magnitudes, one bit per cycle, sign fix-up in a final cycle.
//               Fixed latency: START edge + WIDTH CALC edges + 1 FIX edge.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,
   muldiv_unit_if.slave    bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [CW-1:0]    c_LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] c_ALL_ONES  = '1;
   localparam logic [WIDTH-1:0] c_ZERO      = '0;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_div0_out;

   // Captured with START
   logic               r_is_div;   // OP[1]: divide family
   logic               r_div0;     // divide with B == 0
   logic               r_neg;      // sign(A) ^ sign(B), signed ops only
   logic               r_sa;       // sign(A), signed ops only
   logic [WIDTH-1:0]   r_a_raw;    // raw A, returned in HI on divide-by-zero

   // Multiply datapath: {accumulator, multiplier} and the multiplicand
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mcand;

   // Divide datapath: partial remainder (one guard bit), dividend/quotient
   // shift register and divisor
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dsor;

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   // ------------------------------------------------------------------------
   // Launch decode and operand magnitudes
   // ------------------------------------------------------------------------
   logic               w_idle;
   logic               w_start;
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_start  = w_idle & bus.i_start;
   assign w_signed = ~bus.i_op[0];
   assign w_a_neg  = w_signed & bus.i_a[WIDTH-1];
   assign w_b_neg  = w_signed & bus.i_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -bus.i_a : bus.i_a;
   assign w_b_mag  = w_b_neg ? -bus.i_b : bus.i_b;

   // ------------------------------------------------------------------------
   // One multiply step: add multiplicand into the accumulator when the
   // current multiplier LSB is set, then shift the whole pair right. The
   // adder carry becomes the new accumulator MSB.
   // ------------------------------------------------------------------------
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_mnext;

   assign w_madd  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_mnext = r_prod[0] ? {w_madd, r_prod[WIDTH-1:1]}
                              : {1'b0, r_prod[2*WIDTH-1:1]};

   // ------------------------------------------------------------------------
   // One restoring divide step: shift the next dividend bit into the
   // remainder and keep the trial difference when it does not borrow. The
   // trial is two bits wider than the divisor so its sign bit is exact even
   // when the shifted remainder exceeds WIDTH bits.
   // ------------------------------------------------------------------------
   logic [WIDTH+1:0]   w_dshift;
   logic [WIDTH+1:0]   w_dtrial;
   logic               w_dfits;
   logic [WIDTH:0]     w_rem_next;

   assign w_dshift   = {r_rem, r_quo[WIDTH-1]};
   assign w_dtrial   = w_dshift - {2'b00, r_dsor};
   assign w_dfits    = ~w_dtrial[WIDTH+1];
   assign w_rem_next = w_dfits ? w_dtrial[WIDTH:0] : w_dshift[WIDTH:0];

   // ------------------------------------------------------------------------
   // Sign fix-up applied in FIX
   // ------------------------------------------------------------------------
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_prod_fix = r_neg ? -r_prod : r_prod;
   assign w_quo_fix  = r_neg ? -r_quo : r_quo;
   assign w_rem_fix  = r_sa  ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   // Sequencer: IDLE -> CALC (WIDTH iterations) -> FIX -> IDLE, status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div0_out <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div0_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_state <= ST_CALC;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST_ITER) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_state    <= ST_IDLE;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_div0_out <= r_is_div & r_div0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture on launch, then one multiply and one divide step per CALC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_neg    <= 1'b0;
         r_sa     <= 1'b0;
         r_a_raw  <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dsor   <= '0;
      end else if (w_start) begin
         r_is_div <= bus.i_op[1];
         r_div0   <= bus.i_op[1] & (bus.i_b == c_ZERO);
         r_neg    <= w_a_neg ^ w_b_neg;
         r_sa     <= w_a_neg;
         r_a_raw  <= bus.i_a;
         r_prod   <= {c_ZERO, w_b_mag};
         r_mcand  <= w_a_mag;
         r_rem    <= '0;
         r_quo    <= w_a_mag;
         r_dsor   <= w_b_mag;
      end else if (r_state == ST_CALC) begin
         if (r_is_div) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_dfits};
         end else begin
            r_prod <= w_mnext;
         end
      end
   end

   // HI/LO: result write in FIX, mthi/mtlo writes only while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == ST_FIX) begin
         if (!r_is_div) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
         end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= c_ALL_ONES;
         end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
         end
      end else if (w_idle) begin
         if (bus.i_whi) begin
            r_hi <= bus.i_wdata;
         end
         if (bus.i_wlo) begin
            r_lo <= bus.i_wdata;
         end
      end
   end

   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;
   assign bus.o_div0 = r_div0_out;
   assign bus.o_hi   = r_hi;
   assign bus.o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed operand cases,
//               randomized operations against an arithmetic reference model,
//               BUSY/DONE timing, mthi/mtlo writes and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Expected architectural HI/LO as the bench believes them to be
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Architectural result of one operation, from plain integer arithmetic
   task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output logic d0);
      logic signed [63:0] sa64, sb64, sp;
      logic        [63:0] up;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      d0 = 1'b0;
      case (op)
         2'b00: begin
            sa64 = sa;
            sb64 = sb;
            sp   = sa64 * sb64;
            hi   = sp[63:32];
            lo   = sp[31:0];
         end
         2'b01: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
               d0 = 1'b1;
            end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else if (op == 2'b10) begin
               lo = sa / sb;
               hi = sa % sb;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endtask

   // Launch one op at the current negedge and follow it to DONE.
   // disturb: extra START pulses and an mthi write while busy.
   // wr_start: mthi+mtlo in the same cycle as START.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input bit wr_start);
      logic [31:0] eh, el;
      logic        ed0;
      int          k;
      ref_model(op, a, b, eh, el, ed0);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      if (wr_start) begin
         bus.i_whi   = 1'b1;
         bus.i_wlo   = 1'b1;
         bus.i_wdata = $urandom;
         m_hi        = bus.i_wdata;
         m_lo        = bus.i_wdata;
      end
      step();
      bus.i_start = 1'b0;
      bus.i_whi   = 1'b0;
      bus.i_wlo   = 1'b0;
      bus.i_op    = 2'($urandom);
      bus.i_a     = $urandom;
      bus.i_b     = $urandom;
      chk("busy_after_start", 64'(bus.o_busy), 64'd1);
      chk("done_low_in_calc", 64'(bus.o_done), 64'd0);
      k = 0;
      while (bus.o_busy === 1'b1 && k < 40) begin
         if (k == 16) begin
            chk("hi_hold_calc", 64'(bus.o_hi), 64'(m_hi));
            chk("lo_hold_calc", 64'(bus.o_lo), 64'(m_lo));
         end
         bus.i_start = disturb && (k == 5 || k == 20);
         bus.i_whi   = disturb && (k == 10);
         if (disturb && k == 10) bus.i_wdata = 32'hAAAA_5555;
         if (bus.i_start) bus.i_op = 2'($urandom);
         step();
         k++;
      end
      bus.i_start = 1'b0;
      bus.i_whi   = 1'b0;
      chk("busy_cycles", 64'(k), 64'd33);
      chk("done_pulse", 64'(bus.o_done), 64'd1);
      chk("div0_flag", 64'(bus.o_div0), 64'(ed0));
      chk("hi_result", 64'(bus.o_hi), 64'(eh));
      chk("lo_result", 64'(bus.o_lo), 64'(el));
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;

      bus.i_start = 1'b0;
      bus.i_op    = 2'b00;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_whi   = 1'b0;
      bus.i_wlo   = 1'b0;
      bus.i_wdata = '0;
      rst         = 1'b1;
      repeat (3) step();

      chk("rst_busy", 64'(bus.o_busy), 64'd0);
      chk("rst_done", 64'(bus.o_done), 64'd0);
      chk("rst_div0", 64'(bus.o_div0), 64'd0);
      chk("rst_hi", 64'(bus.o_hi), 64'd0);
      chk("rst_lo", 64'(bus.o_lo), 64'd0);
      rst = 1'b0;
      step();

      // Directed cases
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
      run_op(2'b11, 32'd100, 32'd7, 0, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(2'b10, 32'h1234_5678, 32'd0, 0, 0);
      run_op(2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0);
      step();
      chk("done_one_cycle", 64'(bus.o_done), 64'd0);
      chk("div0_one_cycle", 64'(bus.o_div0), 64'd0);

      // Ignored START pulses and mthi while busy; only one DONE follows
      run_op(2'b01, 32'h0001_2345, 32'h0000_6789, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("single_done", 64'(bus.o_done), 64'd0);
         chk("idle_after_done", 64'(bus.o_busy), 64'd0);
      end

      // mthi / mtlo in IDLE
      bus.i_whi = 1'b1; bus.i_wdata = 32'hAAAA_5555;
      step();
      bus.i_whi = 1'b0;
      chk("mthi_hi", 64'(bus.o_hi), 64'h0000_0000_AAAA_5555);
      chk("mthi_lo_kept", 64'(bus.o_lo), 64'(m_lo));
      m_hi = 32'hAAAA_5555;
      bus.i_wlo = 1'b1; bus.i_wdata = 32'h1357_9BDF;
      step();
      bus.i_wlo = 1'b0;
      chk("mtlo_lo", 64'(bus.o_lo), 64'h0000_0000_1357_9BDF);
      chk("mtlo_hi_kept", 64'(bus.o_hi), 64'(m_hi));
      m_lo = 32'h1357_9BDF;
      bus.i_whi = 1'b1; bus.i_wlo = 1'b1; bus.i_wdata = 32'h0F0F_F0F0;
      step();
      bus.i_whi = 1'b0; bus.i_wlo = 1'b0;
      chk("mthilo_hi", 64'(bus.o_hi), 64'h0000_0000_0F0F_F0F0);
      chk("mthilo_lo", 64'(bus.o_lo), 64'h0000_0000_0F0F_F0F0);
      m_hi = 32'h0F0F_F0F0;
      m_lo = 32'h0F0F_F0F0;

      // Write in the START cycle, then a back-to-back launch in the DONE cycle
      run_op(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0);

      // Randomized operations
      for (int i = 0; i < 16; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         case ($urandom_range(0, 5))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 15));
            2:       r_b = -32'($urandom_range(1, 15));
            default: r_b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) r_a = r_a >> $urandom_range(0, 31);
         run_op(r_op, r_a, r_b, 0, 0);
      end

      // Reset in the middle of CALC aborts without DONE
      bus.i_start = 1'b1; bus.i_op = 2'b01; bus.i_a = 32'h0000_1111; bus.i_b = 32'h0000_2222;
      step();
      bus.i_start = 1'b0;
      repeat (10) step();
      chk("busy_before_abort", 64'(bus.o_busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 64'(bus.o_busy), 64'd0);
      chk("abort_hi", 64'(bus.o_hi), 64'd0);
      chk("abort_lo", 64'(bus.o_lo), 64'd0);
      chk("abort_done", 64'(bus.o_done), 64'd0);
      m_hi = '0;
      m_lo = '0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            chk("no_done_after_abort", {31'd0, bus.o_busy, 31'd0, bus.o_done}, 64'd0);
         end
      end
      chk("idle_after_abort", 64'(bus.o_busy), 64'd0);
      run_op(2'b01, 32'd3, 32'd4, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
